// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants for fetch, decode and hazard unit
package mips_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int PC_STEP = 4;

  localparam logic [31:0] BUBBLE_INSTR = NOP_INSTR;
  localparam logic        BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with write enable and bubble load
module if_id_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] pc4_i,
  input  logic [31:0]       instr_i,
  output logic [ADDR_W-1:0] pc4_o,
  output logic [31:0]       instr_o,
  output logic              valid_o
);

  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;

  // Bubble beats write; with neither, all three fields hold together.
  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bubble_i) begin
      pc4_d   = '0;
      instr_d = BUBBLE_INSTR;
      valid_d = BUBBLE_VALID;
    end else if (write_i) begin
      pc4_d   = pc4_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  // Register the IF/ID fields; reset clears to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc4_q   <= '0;
      instr_q <= BUBBLE_INSTR;
      valid_q <= BUBBLE_VALID;
    end else begin
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, next-PC mux, IF/ID register, counters
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_write_i,
  input  logic              ifid_write_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  output logic [31:0]       ifid_instr_o,
  output logic              ifid_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              stall_evt, flush_evt;
  logic              unused_addr_bits;

  // Redirect targets are word-aligned by dropping their low two bits.
  assign unused_addr_bits = ^redirect_addr_i[1:0];

  assign pc_plus4  = pc_q + ADDR_W'(PC_STEP);
  assign stall_evt = start && !pc_write_i && !redirect_i;
  assign flush_evt = start && flush_i;

  // Next PC: idle reloads reset PC, redirect beats the HDU stall, else step or hold.
  always_comb begin
    pc_d = pc_q;
    if (!start) begin
      pc_d = RESET_PC_ALIGNED;
    end else if (redirect_i) begin
      pc_d = {redirect_addr_i[ADDR_W-1:2], 2'b00};
    end else if (pc_write_i) begin
      pc_d = pc_plus4;
    end
  end

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_evt && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC_ALIGNED;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst),
    .bubble_i (!start || flush_i),
    .write_i  (ifid_write_i),
    .pc4_i    (pc_plus4),
    .instr_i  (imem_instr_i),
    .pc4_o    (ifid_pc4_o),
    .instr_o  (ifid_instr_o),
    .valid_o  (ifid_valid_o)
  );

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pc_write;
  logic        ifid_write;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_addr;

  logic [31:0] imem_addr, imem_instr;
  logic [31:0] pc, ifid_pc4, ifid_instr;
  logic        ifid_valid;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] imem_addr_s, imem_instr_s;
  logic [31:0] pc_s, ifid_pc4_s, ifid_instr_s;
  logic        ifid_valid_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory: word index tagged with 0xA5 in the top byte.
  assign imem_instr   = 32'hA500_0000 ^ {2'b00, imem_addr[31:2]};
  assign imem_instr_s = 32'hA500_0000 ^ {2'b00, imem_addr_s[31:2]};

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pc_write_i      (pc_write),
    .ifid_write_i    (ifid_write),
    .flush_i         (flush),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .imem_addr_o     (imem_addr),
    .imem_instr_i    (imem_instr),
    .pc_o            (pc),
    .ifid_pc4_o      (ifid_pc4),
    .ifid_instr_o    (ifid_instr),
    .ifid_valid_o    (ifid_valid),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  fetch_stage #(.CNT_W(2)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pc_write_i      (pc_write),
    .ifid_write_i    (ifid_write),
    .flush_i         (flush),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .imem_addr_o     (imem_addr_s),
    .imem_instr_i    (imem_instr_s),
    .pc_o            (pc_s),
    .ifid_pc4_o      (ifid_pc4_s),
    .ifid_instr_o    (ifid_instr_s),
    .ifid_valid_o    (ifid_valid_s),
    .stall_cnt_o     (stall_cnt_s),
    .flush_cnt_o     (flush_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic pw, input logic iw,
                       input logic fl, input logic rd, input logic [31:0] ra);
    start         = s;
    pc_write      = pw;
    ifid_write    = iw;
    flush         = fl;
    redirect      = rd;
    redirect_addr = ra;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc4,
                          input logic [31:0] instr, input logic valid);
    chk({tag, "_pc4"},   ifid_pc4,   pc4);
    chk({tag, "_instr"}, ifid_instr, instr);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush", {16'd0, flush_cnt}, 32'd0);

    @(negedge clk);
    rst = 1'b1;

    // Idle for three cycles with start low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_pc", pc, 32'h0);
      chk("idle_valid", {31'd0, ifid_valid}, 32'd0);
      chk("idle_stall", {16'd0, stall_cnt}, 32'd0);
    end

    // Sequential fetch.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("seq1_pc", pc, 32'h4);
    chk_ifid("seq1", 32'h4, 32'hA500_0000, 1'b1);
    tick();
    chk("seq2_pc", pc, 32'h8);
    chk_ifid("seq2", 32'h8, 32'hA500_0001, 1'b1);
    chk("seq_stall", {16'd0, stall_cnt}, 32'd0);
    chk("seq_flush", {16'd0, flush_cnt}, 32'd0);

    // Two-cycle stall at PC=8.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("stall_pc", pc, 32'h8);
    chk_ifid("stall", 32'h8, 32'hA500_0001, 1'b1);
    chk("stall_cnt2", {16'd0, stall_cnt}, 32'd2);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("resume_pc", pc, 32'hC);
    chk_ifid("resume", 32'hC, 32'hA500_0002, 1'b1);

    // Redirect with flush at PC=12; pc_write low must not block it.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0043);
    tick();
    chk("redir_pc", pc, 32'h40);
    chk("redir_imem_addr", imem_addr, 32'h40);
    chk_ifid("redir", 32'h0, 32'h0, 1'b0);
    chk("redir_flush", {16'd0, flush_cnt}, 32'd1);
    chk("redir_stall", {16'd0, stall_cnt}, 32'd2);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("tgt_pc", pc, 32'h44);
    chk_ifid("tgt", 32'h44, 32'hA500_0010, 1'b1);

    // PC wrap from the top of the address space.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    tick();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_flush", {16'd0, flush_cnt}, 32'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk_ifid("wrap", 32'h0, 32'h9AFF_FFFF, 1'b1);

    // Five stall cycles: narrow counter saturates at 3.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("sat1_stall_s", {30'd0, stall_cnt_s}, 32'd3);
    for (int i = 0; i < 4; i++) tick();
    chk("sat5_stall_s", {30'd0, stall_cnt_s}, 32'd3);
    chk("sat5_stall", {16'd0, stall_cnt}, 32'd7);
    chk("sat5_flush_s", {30'd0, flush_cnt_s}, 32'd2);
    chk("sat5_pc", pc, 32'h0);

    // start low mid-run ignores everything else.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("pre_idle_pc", pc, 32'h4);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    tick();
    chk("midle_pc", pc, 32'h0);
    chk_ifid("midle", 32'h0, 32'h0, 1'b0);
    chk("midle_stall", {16'd0, stall_cnt}, 32'd7);
    chk("midle_flush", {16'd0, flush_cnt}, 32'd2);

    // Asynchronous reset between edges.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("prerst_pc", pc, 32'h8);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("arst_flush", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("restart_pc", pc, 32'h4);
    chk_ifid("restart", 32'h4, 32'hA500_0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
